// File: rtl/bus_burst_mem_slave.sv
// bus_burst_mem_slave: parametrised burst RAM slave for the or1420 bus.
// Ports: clk_i/rst_i (sync, active high); bus_*_i master side inputs;
//   bus_addrData_o read data, bus_dataValid_o read beat valid,
//   bus_endTransaction_o end/error-end pulse, bus_busy_o write stall,
//   bus_error_o misaligned access pulse. All outputs 0 when idle.
// Optional: BUS_BURST_MEM_SLAVE_BUSY_INJECT_EN adds LFSR busy injection.
`timescale 1ns/1ps
module bus_burst_mem_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MEM_WORDS    = 65536,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] bus_addrData_i,
    input  logic [3:0]  bus_byteEnables_i,
    input  logic [7:0]  bus_burstSize_i,
    input  logic        bus_readNWrite_i,
    input  logic        bus_beginTransaction_i,
    input  logic        bus_endTransaction_i,
    input  logic        bus_dataValid_i,
    output logic [31:0] bus_addrData_o,
    output logic        bus_endTransaction_o,
    output logic        bus_dataValid_o,
    output logic        bus_busy_o,
    output logic        bus_error_o
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        IDLE, WRITE, RWAIT, READ, REND, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [8:0]    beats_q, beats_d;
    logic [3:0]    wait_q, wait_d;
    logic [31:0]   mem_q [MEM_WORDS];

    logic          sel;
    logic          wr_en;
    logic [AW-1:0] word_idx;

    // 33-bit compare so a window ending at 2^32 does not overflow
    assign sel = (bus_addrData_i >= BASE_ADDR) &&
                 (({1'b0, bus_addrData_i} - {1'b0, BASE_ADDR}) < SPAN);
    assign word_idx = AW'((bus_addrData_i - BASE_ADDR) >> 2);

`ifdef BUS_BURST_MEM_SLAVE_BUSY_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois form of x^16+x^14+x^13+x^11+1
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    assign bus_busy_o = (state_q == WRITE) && lfsr_q[0];
`else
    assign bus_busy_o = 1'b0;
`endif

    // beats_q counts remaining beats; surplus write beats are dropped
    assign wr_en = (state_q == WRITE) && bus_dataValid_i &&
                   !bus_busy_o && (beats_q != 9'd0) && !rst_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beats_d = beats_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (bus_beginTransaction_i && sel) begin
                    ptr_d   = word_idx;
                    beats_d = 9'(bus_burstSize_i) + 9'd1;
                    wait_d  = 4'(READ_LATENCY - 1);
                    if (bus_addrData_i[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else if (!bus_readNWrite_i) begin
                        state_d = WRITE;
                    end else if (READ_LATENCY == 1) begin
                        state_d = READ;
                    end else begin
                        state_d = RWAIT;
                    end
                end
            end
            WRITE: begin
                if (wr_en) begin
                    ptr_d   = ptr_q + 1'b1;
                    beats_d = beats_q - 9'd1;
                end
                if (bus_endTransaction_i) begin
                    state_d = IDLE;
                end
            end
            RWAIT: begin
                if (bus_endTransaction_i) begin
                    state_d = IDLE;
                end else if (wait_q == 4'd1) begin
                    state_d = READ;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            READ: begin
                if (bus_endTransaction_i) begin
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    beats_d = beats_q - 9'd1;
                    if (beats_q == 9'd1) begin
                        state_d = REND;
                    end
                end
            end
            REND:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_dataValid_o      = (state_q == READ);
        bus_addrData_o       = 32'h0;
        bus_endTransaction_o = (state_q == REND) || (state_q == ERR);
        bus_error_o          = (state_q == ERR);
        if (state_q == READ) begin
            bus_addrData_o = mem_q[ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            beats_q <= '0;
            wait_q  <= '0;
`ifdef BUS_BURST_MEM_SLAVE_BUSY_INJECT_EN
            lfsr_q  <= 16'hACE1;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beats_q <= beats_d;
            wait_q  <= wait_d;
`ifdef BUS_BURST_MEM_SLAVE_BUSY_INJECT_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    // Storage has no reset so contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_byteEnables_i[b]) begin
                    mem_q[ptr_q][8*b +: 8] <= bus_addrData_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_burst_mem_slave.sv
// tb_bus_burst_mem_slave: randomized bench for bus_burst_mem_slave
// with a word-array memory model and a bus-timeline reference.
`timescale 1ns/1ps
module tb_bus_burst_mem_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int N = 128;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] bus_addrData_i;
    logic [3:0]  bus_byteEnables_i;
    logic [7:0]  bus_burstSize_i;
    logic        bus_readNWrite_i;
    logic        bus_beginTransaction_i;
    logic        bus_endTransaction_i;
    logic        bus_dataValid_i;
    logic [31:0] bus_addrData_o;
    logic        bus_endTransaction_o;
    logic        bus_dataValid_o;
    logic        bus_busy_o;
    logic        bus_error_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [N];
    logic [31:0] wdata [300];
    logic [3:0]  wbe   [300];
    logic [15:0] lfsr_ref;

    always #5 clk = ~clk;

    bus_burst_mem_slave #(
        .BASE_ADDR(BASE),
        .MEM_WORDS(N),
        .READ_LATENCY(L)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus_addrData_i(bus_addrData_i),
        .bus_byteEnables_i(bus_byteEnables_i),
        .bus_burstSize_i(bus_burstSize_i),
        .bus_readNWrite_i(bus_readNWrite_i),
        .bus_beginTransaction_i(bus_beginTransaction_i),
        .bus_endTransaction_i(bus_endTransaction_i),
        .bus_dataValid_i(bus_dataValid_i),
        .bus_addrData_o(bus_addrData_o),
        .bus_endTransaction_o(bus_endTransaction_o),
        .bus_dataValid_o(bus_dataValid_o),
        .bus_busy_o(bus_busy_o),
        .bus_error_o(bus_error_o)
    );

    // Reference pseudo-random busy source, restarted by reset
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    always @(posedge clk) begin
        lfsr_ref <= rst_i ? 16'hACE1 : lfsr_step(lfsr_ref);
    end

    function automatic logic exp_busy();
`ifdef BUS_BURST_MEM_SLAVE_BUSY_INJECT_EN
        return lfsr_ref[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [35:0] obs();
        return {bus_addrData_o, bus_dataValid_o,
                bus_endTransaction_o, bus_error_o, bus_busy_o};
    endfunction

    task automatic check_idle(input string name);
        tests++;
        if (obs() !== 36'h0) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, obs(), 36'h0);
        end
    endtask

    // mode 0: end strobe after beats, 1: end with last beat, 2: reset
    task automatic do_write(input logic [31:0] addr, input int burst,
                            input int nbeats, input int mode);
        int w;
        int stall;
        logic b;
        logic [35:0] e;
        @(negedge clk);
        bus_beginTransaction_i = 1'b1;
        bus_addrData_i = addr;
        bus_readNWrite_i = 1'b0;
        bus_burstSize_i = 8'(burst);
        @(negedge clk);
        bus_beginTransaction_i = 1'b0;
        w = int'((addr - BASE) >> 2) % N;
        for (int i = 0; i < nbeats; i++) begin
            bus_addrData_i = wdata[i];
            bus_byteEnables_i = wbe[i];
            bus_dataValid_i = 1'b1;
            stall = 0;
            forever begin
                b = bus_busy_o;
                e = {35'h0, exp_busy()};
                tests++;
                if (obs() !== e) begin
                    fails++;
                    $display("FAIL write_beat %0d: got %h expected %h",
                             i, obs(), e);
                end
                if (!b) begin
                    if (mode == 1 && i == nbeats - 1)
                        bus_endTransaction_i = 1'b1;
                    @(negedge clk);
                    break;
                end
                @(negedge clk);
                stall++;
                if (stall > 64) begin
                    tests++;
                    fails++;
                    $display("FAIL write_stall: got %0d expected <=64",
                             stall);
                    break;
                end
            end
            if (i <= burst) begin
                for (int l = 0; l < 4; l++)
                    if (wbe[i][l]) model[w][8*l +: 8] = wdata[i][8*l +: 8];
                w = (w + 1) % N;
            end
        end
        bus_dataValid_i = 1'b0;
        bus_endTransaction_i = 1'b0;
        if (mode == 0) begin
            bus_endTransaction_i = 1'b1;
            @(negedge clk);
            bus_endTransaction_i = 1'b0;
        end else if (mode == 2) begin
            rst_i = 1'b1;
            @(negedge clk);
            rst_i = 1'b0;
            check_idle("after_reset");
            bus_addrData_i = 32'hBAD0_BAD0;
            bus_dataValid_i = 1'b1;
            @(negedge clk);
            bus_dataValid_i = 1'b0;
        end
        check_idle("write_done");
    endtask

    // flags bit0: stray begin during read, bit1: end strobe with begin
    task automatic do_read(input logic [31:0] addr, input int burst,
                           input int abort_after, input int flags);
        int w;
        int nb;
        bit ab;
        logic [35:0] e;
        @(negedge clk);
        bus_beginTransaction_i = 1'b1;
        bus_addrData_i = addr;
        bus_readNWrite_i = 1'b1;
        bus_burstSize_i = 8'(burst);
        bus_endTransaction_i = flags[1];
        @(negedge clk);
        bus_beginTransaction_i = 1'b0;
        bus_endTransaction_i = 1'b0;
        w = int'((addr - BASE) >> 2) % N;
        nb = burst + 1;
        ab = 1'b0;
        for (int k = 1; k <= L + nb + 1; k++) begin
            e = 36'h0;
            if (!ab) begin
                if (k >= L && k < L + nb)
                    e = {model[(w + k - L) % N], 4'b1000};
                else if (k == L + nb)
                    e = {32'h0, 4'b0100};
            end
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL read_k%0d @%h: got %h expected %h",
                         k, addr, obs(), e);
            end
            if (abort_after > 0 && k == L + abort_after - 1) begin
                bus_endTransaction_i = 1'b1;
                ab = 1'b1;
            end
            if (flags[0] && k == 1) begin
                bus_beginTransaction_i = 1'b1;
                bus_addrData_i = 32'h0000_0102;
                bus_readNWrite_i = 1'b0;
            end
            @(negedge clk);
            bus_endTransaction_i = 1'b0;
            bus_beginTransaction_i = 1'b0;
        end
    endtask

    task automatic do_probe(input logic [31:0] addr, input logic rnw,
                            input logic exp_err);
        logic [35:0] e;
        @(negedge clk);
        bus_beginTransaction_i = 1'b1;
        bus_addrData_i = addr;
        bus_readNWrite_i = rnw;
        bus_burstSize_i = 8'd3;
        bus_byteEnables_i = 4'hF;
        @(negedge clk);
        bus_beginTransaction_i = 1'b0;
        bus_addrData_i = 32'hBADB_AD00;
        bus_dataValid_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            e = (k == 1 && exp_err) ? 36'h6 : 36'h0;
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL probe_k%0d @%h: got %h expected %h",
                         k, addr, obs(), e);
            end
            @(negedge clk);
        end
        bus_dataValid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("in_reset");
        rst_i = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            wdata[i] = 32'h0;
            wbe[i] = 4'hF;
        end
        do_write(BASE, N - 1, N, 0);
    endtask

    task automatic test_write_read();
        wdata[0] = 32'hDEAD_BEEF;
        wbe[0] = 4'hF;
        do_write(32'h100, 0, 1, 0);
        do_read(32'h100, 0, 0, 0);
    endtask

    task automatic test_bytes();
        wdata[0] = 32'hFFFF_FFFF;
        wbe[0] = 4'hF;
        do_write(32'h104, 0, 1, 0);
        wdata[0] = 32'h1122_3344;
        wbe[0] = 4'b0101;
        do_write(32'h104, 0, 1, 0);
        tests++;
        if (model[65] !== 32'hFF22_FF44) begin
            fails++;
            $display("FAIL byte_model: got %h expected %h",
                     model[65], 32'hFF22_FF44);
        end
        do_read(32'h104, 0, 0, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 32'(i + 1);
            wbe[i] = 4'hF;
        end
        do_write(32'((N - 2) * 4), 3, 4, 0);
        do_read(32'((N - 2) * 4), 3, 0, 0);
        do_read(32'h0, 1, 0, 0);
    endtask

    task automatic test_errors();
        do_probe(32'h102, 1'b1, 1'b1);
        do_probe(32'h101, 1'b0, 1'b1);
        do_probe(32'(N * 4), 1'b1, 1'b0);
        do_probe(32'(N * 4), 1'b0, 1'b0);
        do_probe(32'(N * 4 + 2), 1'b1, 1'b0);
        do_read(32'h100, 1, 0, 0);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) begin
            wdata[i] = $urandom;
            wbe[i] = 4'hF;
        end
        do_write(32'h40, 7, 8, 0);
        do_read(32'h40, 7, 3, 0);
        do_read(32'h40, 7, 1, 0);
        do_read(32'h44, 2, 0, 0);
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 3; i++) begin
            wdata[i] = $urandom;
            wbe[i] = 4'hF;
        end
        do_write(32'h80, 7, 3, 2);
        do_read(32'h80, 5, 0, 0);
    endtask

    task automatic test_busy();
        for (int i = 0; i < 32; i++) begin
            wdata[i] = $urandom;
            wbe[i] = 4'hF;
        end
        do_write(32'h0C0, 31, 32, 0);
        do_read(32'h0C0, 31, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wdata[i] = $urandom;
            wbe[i] = 4'(i + 3);
        end
        do_write(32'h140, 1, 4, 1);
        do_read(32'h140, 3, 0, 1);
        do_read(32'h13C, 5, 0, 2);
        do_read(32'h140, 0, 0, 0);
    endtask

    task automatic test_random();
        int burst;
        int extra;
        for (int it = 0; it < 24; it++) begin
            burst = $urandom_range(0, 15);
            extra = $urandom_range(0, 2);
            for (int i = 0; i < burst + 1 + extra; i++) begin
                wdata[i] = $urandom;
                wbe[i] = 4'($urandom_range(0, 15));
            end
            do_write(32'($urandom_range(0, N - 1) * 4), burst,
                     burst + 1 + extra, int'($urandom_range(0, 1)));
            burst = $urandom_range(0, 20);
            do_read(32'($urandom_range(0, N - 1) * 4), burst,
                    ($urandom_range(0, 3) == 0) ? 2 : 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        bus_addrData_i = 32'h0;
        bus_byteEnables_i = 4'h0;
        bus_burstSize_i = 8'h0;
        bus_readNWrite_i = 1'b0;
        bus_beginTransaction_i = 1'b0;
        bus_endTransaction_i = 1'b0;
        bus_dataValid_i = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 32'h0;
        test_reset();
        test_fill();
        test_write_read();
        test_bytes();
        test_wrap();
        test_errors();
        test_abort();
        test_reset_mid_write();
        test_busy();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
